// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command responder.
package uart_cmd_pkg;

  localparam int unsigned REG_W    = 8;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned TO_W     = 24;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_DATA  = 3'd2,
    ST_EXEC      = 3'd3,
    ST_SEND      = 3'd4,
    ST_WAIT_BUSY = 3'd5,
    ST_WAIT_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/uart_cmd_tx_seq.sv
// Sends a 1- or 2-byte response through the transmitter handshake, then pulses done.
module uart_cmd_tx_seq
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       launch,
  input  logic       two_bytes,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       done
);

  state_e     state_q, state_d;
  logic       pend_q, pend_d;
  logic [7:0] cur_q, cur_d;
  logic [7:0] nxt_q, nxt_d;
  logic [7:0] data_d;
  logic       start_d, done_d;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      cur_q    <= 8'h00;
      nxt_q    <= 8'h00;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cur_q    <= cur_d;
      nxt_q    <= nxt_d;
      tx_start <= start_d;
      tx_data  <= data_d;
      done     <= done_d;
    end
  end

  // Handshake sequencing: SEND -> WAIT_BUSY -> WAIT_DONE, repeat once for a second byte.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    data_d  = tx_data;
    start_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          cur_d   = byte0;
          nxt_d   = byte1;
          pend_d  = two_bytes;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          start_d = 1'b1;
          data_d  = cur_q;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!tx_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_ready) begin
          if (pend_q) begin
            cur_d   = nxt_q;
            pend_d  = 1'b0;
            state_d = ST_SEND;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Three-byte UART command decoder driving a 4x8 register file with K/E responses.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter logic [23:0] INTERBYTE_TIMEOUT = 24'd1_000_000
) (
  input  logic                      clk_10ns,
  input  logic                      uart_reset,
  input  logic [7:0]                uart_received_data,
  input  logic                      uart_rx_valid,
  input  logic                      uart_tx_ready,
  output logic                      uart_tx_start,
  output logic [7:0]                uart_transmit_data,
  output logic [NUM_REGS*REG_W-1:0] reg_out,
  output logic                      cmd_done,
  output logic [7:0]                err_count
);

  state_e          state_q, state_d;
  logic            rx_valid_q;
  logic            rx_pulse;
  logic [7:0]      rx_data;
  logic [7:0]      opcode_q, addr_q, data_q;
  logic [TO_W-1:0] to_cnt;

  logic            in_frame_c, timeout_c, byte_c, valid_cmd_c, launch_c, is_read_c;
  logic [7:0]      rsp0_c, rsp1_c;
  logic [4:0]      reg_sel_c;
  logic            tx_done;

  // Registered rising-edge detect on the receiver valid level, with its data.
  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset) begin
      rx_valid_q <= 1'b0;
      rx_pulse   <= 1'b0;
      rx_data    <= 8'h00;
    end else begin
      rx_valid_q <= uart_rx_valid;
      rx_pulse   <= uart_rx_valid & ~rx_valid_q;
      rx_data    <= uart_received_data;
    end
  end

  assign in_frame_c  = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
  assign timeout_c   = in_frame_c && (to_cnt == INTERBYTE_TIMEOUT);
  assign byte_c      = rx_pulse && !timeout_c;
  assign is_read_c   = (opcode_q == OP_READ);
  assign valid_cmd_c = ((opcode_q == OP_WRITE) || is_read_c) && (addr_q[7:2] == 6'd0);
  assign reg_sel_c   = {addr_q[1:0], 3'b000};
  assign launch_c    = (state_q == ST_EXEC);
  assign rsp0_c      = valid_cmd_c ? RSP_OK : RSP_ERR;
  assign rsp1_c      = reg_out[reg_sel_c +: REG_W];

  // Frame state register.
  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Frame sequencing; ST_SEND covers the whole response handled by the sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (rx_pulse) state_d = ST_GET_ADDR;
      ST_GET_ADDR: begin
        if (timeout_c)   state_d = ST_IDLE;
        else if (byte_c) state_d = ST_GET_DATA;
      end
      ST_GET_DATA: begin
        if (timeout_c)   state_d = ST_IDLE;
        else if (byte_c) state_d = ST_EXEC;
      end
      ST_EXEC:     state_d = ST_SEND;
      ST_SEND:     if (tx_done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Inter-byte timeout counter, running only while a frame is partially received.
  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset)                              to_cnt <= '0;
    else if (in_frame_c && !timeout_c && !rx_pulse) to_cnt <= to_cnt + TO_W'(1);
    else                                          to_cnt <= '0;
  end

  // Capture opcode, address and data bytes of the frame.
  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset) begin
      opcode_q <= 8'h00;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
    end else begin
      if (state_q == ST_IDLE && rx_pulse)     opcode_q <= rx_data;
      if (state_q == ST_GET_ADDR && byte_c)   addr_q   <= rx_data;
      if (state_q == ST_GET_DATA && byte_c)   data_q   <= rx_data;
    end
  end

  // Register file write and saturating error count, both decided in EXEC.
  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset) begin
      reg_out   <= '0;
      err_count <= 8'h00;
    end else if (state_q == ST_EXEC) begin
      if (valid_cmd_c && !is_read_c) reg_out[reg_sel_c +: REG_W] <= data_q;
      if (!valid_cmd_c && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  uart_cmd_tx_seq u_tx_seq (
    .clk       (clk_10ns),
    .rst_n     (uart_reset),
    .launch    (launch_c),
    .two_bytes (valid_cmd_c && is_read_c),
    .byte0     (rsp0_c),
    .byte1     (rsp1_c),
    .tx_ready  (uart_tx_ready),
    .tx_start  (uart_tx_start),
    .tx_data   (uart_transmit_data),
    .done      (tx_done)
  );

  assign cmd_done = tx_done;

endmodule
